// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parameterised register file.
// Latency: none (package only).
// Backpressure: none.
package regfile_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;

  localparam int WP_A = 0;
  localparam int WP_B = 1;

  // Address width for n entries; never below 1 so a single-register file still has a port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, hardwired zero, write bypass, busy qualification.
// Latency: zero (pure combinational).
// Backpressure: none; rd_busy tells decode to stall.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_ok_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              wr_ok_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic [DEPTH-1:0]  busy_vec,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

  logic addr_ok;
  logic hit_a;
  logic hit_b;

  assign addr_ok = ({1'b0, addr} < NREG) && !((ZERO_REG != 0) && (addr == '0));
  assign hit_a   = (BYPASS != 0) && wr_ok_a && (wa_a == addr);
  assign hit_b   = (BYPASS != 0) && wr_ok_b && (wa_b == addr);

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      if (hit_a)      rd_data = wd_a;
      else if (hit_b) rd_data = wd_b;
      else            rd_data = stored;
    end
  end

  // A write landing this cycle satisfies the pending producer when it is forwarded.
  assign rd_busy = addr_ok && busy_vec[addr] && !(hit_a || hit_b);

endmodule

// File: rtl/param_regfile.sv
// Two-write, NUM_RD-read register file with bypass, optional zero R0 and busy scoreboard.
// Latency: reads zero-cycle; writes and scoreboard commit on the rising edge.
// Backpressure: none; rd_busy/busy flag pending producers so decode can stall.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        wa_a,
  input  logic [DATA_W-1:0]        wd_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        wa_b,
  input  logic [DATA_W-1:0]        wd_b,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     collision_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

  // Storage is padded to a power of two so any address indexes safely; the pad never gets written.
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [NUM_REGS-1:0] busy_q;
  logic [DEPTH-1:0]    busy_pad;
  logic                collision_q;

  logic              wr_ok [2];
  logic [ADDR_W-1:0] wr_adr [2];
  logic [DATA_W-1:0] wr_dat [2];
  logic              set_ok;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_adr[WP_A] = wa_a;
  assign wr_adr[WP_B] = wa_b;
  assign wr_dat[WP_A] = wd_a;
  assign wr_dat[WP_B] = wd_b;
  assign wr_ok[WP_A]  = we_a && addr_legal(wa_a);
  assign wr_ok[WP_B]  = we_b && addr_legal(wa_b);
  assign set_ok       = sb_set && addr_legal(sb_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      busy_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok[WP_A] && (wr_adr[WP_A] == ADDR_W'(r)))      regs[r] <= wr_dat[WP_A];
        else if (wr_ok[WP_B] && (wr_adr[WP_B] == ADDR_W'(r))) regs[r] <= wr_dat[WP_B];

        // A fresh issue outranks a retiring write: the new producer is still outstanding.
        if (set_ok && (sb_addr == ADDR_W'(r)))
          busy_q[r] <= 1'b1;
        else if ((wr_ok[WP_A] && (wr_adr[WP_A] == ADDR_W'(r))) ||
                 (wr_ok[WP_B] && (wr_adr[WP_B] == ADDR_W'(r))))
          busy_q[r] <= 1'b0;
      end
      collision_q <= wr_ok[WP_A] && wr_ok[WP_B] && (wr_adr[WP_A] == wr_adr[WP_B]);
    end
  end

  always_comb begin
    busy_pad = '0;
    busy_pad[NUM_REGS-1:0] = busy_q;
  end

  assign busy          = busy_q;
  assign collision_err = collision_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
      .stored   (regs[rd_addr[i*ADDR_W +: ADDR_W]]),
      .wr_ok_a  (wr_ok[WP_A]),
      .wa_a     (wa_a),
      .wd_a     (wd_a),
      .wr_ok_b  (wr_ok[WP_B]),
      .wa_b     (wa_b),
      .wd_b     (wd_b),
      .busy_vec (busy_pad),
      .rd_data  (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench driving three configurations from one stimulus stream:
// d0 default (bypass), d1 no bypass, d2 zero R0 with six registers.
module tb_param_regfile;

  logic        clk;
  logic        rst;
  logic        we_a, we_b, sb_set;
  logic [2:0]  wa_a, wa_b, sb_addr;
  logic [15:0] wd_a, wd_b;
  logic [5:0]  rd_addr;

  logic [31:0] d0_rd_data, d1_rd_data, d2_rd_data;
  logic [1:0]  d0_rd_busy, d1_rd_busy, d2_rd_busy;
  logic [7:0]  d0_busy, d1_busy;
  logic [5:0]  d2_busy;
  logic        d0_col, d1_col, d2_col;

  int total = 0;
  int bad   = 0;

  param_regfile #(.BYPASS(1), .ZERO_REG(0), .NUM_REGS(8)) d0 (
    .clk(clk), .rst(rst), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .rd_addr(rd_addr),
    .rd_data(d0_rd_data), .rd_busy(d0_rd_busy), .sb_set(sb_set),
    .sb_addr(sb_addr), .busy(d0_busy), .collision_err(d0_col));

  param_regfile #(.BYPASS(0), .ZERO_REG(0), .NUM_REGS(8)) d1 (
    .clk(clk), .rst(rst), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .rd_addr(rd_addr),
    .rd_data(d1_rd_data), .rd_busy(d1_rd_busy), .sb_set(sb_set),
    .sb_addr(sb_addr), .busy(d1_busy), .collision_err(d1_col));

  param_regfile #(.BYPASS(1), .ZERO_REG(1), .NUM_REGS(6)) d2 (
    .clk(clk), .rst(rst), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .rd_addr(rd_addr),
    .rd_data(d2_rd_data), .rd_busy(d2_rd_busy), .sb_set(sb_set),
    .sb_addr(sb_addr), .busy(d2_busy), .collision_err(d2_col));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; sb_set = 1'b0;
  endtask

  task automatic set_rd(input logic [2:0] p0, input logic [2:0] p1);
    rd_addr = {p1, p0};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; sb_addr = '0;
    set_rd(3'd3, 3'd3);
    repeat (2) @(negedge clk);
    #1;
    check("reset_rd_data", d0_rd_data, 32'h0);
    check("reset_busy", {24'h0, d0_busy}, 32'h0);
    check("reset_col", {31'h0, d0_col}, 32'h0);

    // A writes R3, read back on both ports next cycle
    @(negedge clk);
    rst = 1'b0;
    we_a = 1'b1; wa_a = 3'd3; wd_a = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("r3_both_d0", d0_rd_data, 32'h1234_1234);
    check("r3_rd_busy", {30'h0, d0_rd_busy}, 32'h0);
    check("r3_both_d1", d1_rd_data, 32'h1234_1234);
    check("r3_both_d2", d2_rd_data, 32'h1234_1234);

    // B writes R5 while port0 reads it: bypass vs stored value
    @(negedge clk);
    we_b = 1'b1; wa_b = 3'd5; wd_b = 16'hBEEF;
    set_rd(3'd5, 3'd3);
    #1;
    check("byp_r5_d0", d0_rd_data, 32'h1234_BEEF);
    check("nobyp_r5_d1_same", d1_rd_data, 32'h1234_0000);
    check("byp_r5_d2", d2_rd_data, 32'h1234_BEEF);
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("nobyp_r5_d1_next", d1_rd_data, 32'h1234_BEEF);

    // Same-address collision: A wins, error pulse for one cycle
    @(negedge clk);
    we_a = 1'b1; wa_a = 3'd2; wd_a = 16'h00AA;
    we_b = 1'b1; wa_b = 3'd2; wd_b = 16'h0055;
    set_rd(3'd2, 3'd2);
    #1;
    check("col_before_edge", {31'h0, d0_col}, 32'h0);
    @(posedge clk);
    #1;
    check("col_pulse_hi", {31'h0, d0_col}, 32'h1);
    @(negedge clk);
    idle();
    #1;
    check("col_r2_a_wins", d0_rd_data, 32'h00AA_00AA);
    check("col_r2_d1", d1_rd_data, 32'h00AA_00AA);
    @(posedge clk);
    #1;
    check("col_pulse_lo", {31'h0, d0_col}, 32'h0);

    // Different addresses on both ports commit together
    @(negedge clk);
    we_a = 1'b1; wa_a = 3'd1; wd_a = 16'h1010;
    we_b = 1'b1; wa_b = 3'd6; wd_b = 16'h6060;
    @(posedge clk);
    #1;
    check("diff_no_col", {31'h0, d0_col}, 32'h0);
    @(negedge clk);
    idle();
    set_rd(3'd1, 3'd6);
    #1;
    check("diff_both_d0", d0_rd_data, 32'h6060_1010);
    check("diff_r6_oor_d2", d2_rd_data, 32'h0000_1010);

    // Scoreboard: set R4, then clear by a B write with bypass
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 3'd4;
    set_rd(3'd4, 3'd1);
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("sb_busy4_d0", {24'h0, d0_busy}, 32'h10);
    check("sb_rdbusy_d0", {30'h0, d0_rd_busy}, 32'h1);
    check("sb_busy4_d2", {26'h0, d2_busy}, 32'h10);
    we_b = 1'b1; wa_b = 3'd4; wd_b = 16'h0F0F;
    #1;
    check("sb_byp_rdbusy_d0", {30'h0, d0_rd_busy}, 32'h0);
    check("sb_byp_data_d0", d0_rd_data, 32'h1010_0F0F);
    check("sb_nobyp_rdbusy_d1", {30'h0, d1_rd_busy}, 32'h1);
    @(posedge clk);
    #1;
    check("sb_cleared_d0", {24'h0, d0_busy}, 32'h0);
    check("sb_cleared_d1", {24'h0, d1_busy}, 32'h0);

    // Set and write of R4 together: set wins
    @(negedge clk);
    idle();
    sb_set = 1'b1; sb_addr = 3'd4;
    we_a = 1'b1; wa_a = 3'd4; wd_a = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("sb_set_wins_d0", {24'h0, d0_busy}, 32'h10);
    check("sb_set_wins_d1", {24'h0, d1_busy}, 32'h10);

    // R0 write + set: hardwired zero on d2, ordinary register on d0
    @(negedge clk);
    we_a = 1'b1; wa_a = 3'd0; wd_a = 16'hFFFF;
    sb_set = 1'b1; sb_addr = 3'd0;
    set_rd(3'd4, 3'd0);
    #1;
    check("zero_r0_same_d2", d2_rd_data, 32'h0000_1111);
    check("zero_r0_byp_d0", d0_rd_data, 32'hFFFF_1111);
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("zero_r0_after_d2", d2_rd_data, 32'h0000_1111);
    check("zero_busy_d2", {26'h0, d2_busy}, 32'h10);
    check("r0_busy_d0", {24'h0, d0_busy}, 32'h11);

    // Address 7: out of range for six registers, legal for eight
    @(negedge clk);
    we_a = 1'b1; wa_a = 3'd7; wd_a = 16'hABCD;
    set_rd(3'd7, 3'd0);
    #1;
    check("oor7_same_d2", d2_rd_data, 32'h0);
    check("r7_byp_d0", d0_rd_data, 32'hFFFF_ABCD);
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("oor7_after_d2", d2_rd_data, 32'h0);
    check("r7_after_d0", d0_rd_data, 32'hFFFF_ABCD);

    // Async reset in mid-cycle clears everything at once
    @(negedge clk);
    we_a = 1'b1; wa_a = 3'd1; wd_a = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    idle();
    set_rd(3'd1, 3'd4);
    #1;
    check("pre_rst_r1", d0_rd_data, 32'h1111_7777);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_data", d0_rd_data, 32'h0);
    check("rst_async_busy", {24'h0, d0_busy}, 32'h0);
    check("rst_async_col", {31'h0, d0_col}, 32'h0);
    check("rst_async_d2", d2_rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_data", d0_rd_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
